uart_stream_rx: RTL

Serial-to-stream UART receiver: the receive side of the UART_STREAM link, the counterpart to the `uart_tx` stream transmitter. It oversamples the asynchronous `rx` line, decodes 8N1 frames (LSB first) and delivers each byte on a valid/ready byte stream through a small FIFO. It sits between the board RX pin and the AXI-Stream fabric of the IP repo.

---
 rtl/uart_stream_pkg.sv | 17 +
 rtl/uart_rx_fifo.sv | 69 ++++++
 rtl/uart_stream_rx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_stream_pkg.sv
// uart_stream_pkg: constants and FSM state type shared by
// the UART_STREAM receive and transmit sides.
package uart_stream_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_STOP_BITS    = 1;
  localparam int UART_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO with head-data output.
// Ports: push/din write, pop read, dout head, full, empty.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_en, rd_en;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign rd_en = pop && !empty;
  // A pop in the same cycle frees the slot a full push needs.
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (wr_en && !rd_en) begin
      cnt_d = cnt_q + CW'(1);
    end else if (rd_en && !wr_en) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_stream_rx.sv
// uart_stream_rx: 8N1 UART receiver feeding a valid/ready byte stream.
// Ports: rx in; m_tdata/m_tvalid/m_tready out stream; frame_err, overrun, busy.
module uart_stream_rx
  import uart_stream_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  // Entry edge counts as one of the half-bit cycles.
  localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_IX = 3'(UART_DATA_BITS - 1);

  uart_rx_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           rx_meta_q, rx_s_q;
  logic           ferr_q, ferr_d;
  logic           ovr_q, ovr_d;
  logic           good;
  logic           fifo_full, fifo_empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    good    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
          cnt_d   = HALF_LD;
        end
      end
      ST_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rx_s_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA;
          cnt_d   = BIT_LD;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = BIT_LD;
          idx_d   = idx_q + 3'd1;
          if (idx_q == LAST_IX) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rx_s_q) begin
          state_d = ST_IDLE;
          good    = 1'b1;
          ovr_d   = fifo_full && !m_tready;
        end else begin
          state_d = ST_WAIT_HIGH;
          ferr_d  = 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (good),
    .din   (shift_q),
    .pop   (m_tready),
    .dout  (m_tdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_tvalid  = !fifo_empty;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
